// File: rtl/udp_pkg.sv
// udp_pkg: shared state encoding, header constants and byte-keep helper for the UDP rx/tx blocks.
package udp_pkg;
    typedef enum logic [2:0] {IDLE, HDR_1, HDR_2, DATA, DONE, ERR} state_t;
    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;
    localparam logic [15:0] CSUM_NONE = 16'h0000;
    localparam logic [15:0] CSUM_GOOD = 16'hFFFF;
    function automatic logic [3:0] keep_for(input logic [15:0] left);
        return left >= 16'd4 ? 4'b1111 : {left >= 16'd1, left >= 16'd2, left >= 16'd3, 1'b0};
    endfunction
endpackage

// File: rtl/udp_csum_accum.sv
// udp_csum_accum: 16-bit ones'-complement accumulator taking two addends per enabled cycle.
module udp_csum_accum (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);
    logic [15:0] sum_q, sum_d, f1;
    logic [16:0] s1, s2;
    // Each fold cannot carry again: the largest 17-bit sum 0x1FFFE folds to 0xFFFF.
    always_comb begin
        s1 = {1'b0, sum_q} + {1'b0, a};
        f1 = s1[15:0] + {15'd0, s1[16]};
        s2 = {1'b0, f1} + {1'b0, b};
        sum_d = clear ? 16'd0 : en ? s2[15:0] + {15'd0, s2[16]} : sum_q;
    end
    always_ff @(posedge clk) sum_q <= reset ? 16'd0 : sum_d;
    assign sum = sum_q;
endmodule

// File: rtl/udp_rx_decoder.sv
// udp_rx_decoder: strips the UDP header, forwards byte-masked payload words and verifies the checksum.
module udp_rx_decoder
    import udp_pkg::*;
#(
    parameter bit          CHECK_EN = 1'b1,
    parameter logic [15:0] MAX_LEN  = 16'd65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in_data,
    input  logic        in_av,
    output logic [15:0] src_port,
    output logic [15:0] dest_port,
    output logic [15:0] pay_len,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_wr,
    output logic        fin,
    output logic        chk_ok,
    output logic        err
);
    state_t      state_q, state_d;
    logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d, left_q, left_d, csum_q, csum_d, sum, l;
    logic [31:0] out_data_q, out_data_d, masked;
    logic [3:0]  out_keep_q, out_keep_d, keep;
    logic        out_wr_q, out_wr_d, fin_q, fin_d, chk_q, chk_d, err_q, err_d;
    logic        take, restart, bad;
    always_comb begin
        l = in_data[31:16];
        keep = state_q == DATA ? keep_for(left_q) : 4'b1111;
        masked = in_data & {{8{keep[3]}}, {8{keep[2]}}, {8{keep[1]}}, {8{keep[0]}}};
        take = in_av && (state_q inside {HDR_1, HDR_2, DATA});
        restart = start && (state_q inside {IDLE, DONE, ERR});
        bad = l < UDP_HDR_BYTES || {1'b0, l} > {1'b0, MAX_LEN};
        state_d = state_q;
        src_d = src_q;
        dst_d = dst_q;
        len_d = len_q;
        left_d = left_q;
        csum_d = csum_q;
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        out_wr_d = 1'b0;
        fin_d = fin_q;
        chk_d = chk_q;
        err_d = err_q;
        if (restart) begin
            state_d = HDR_1;
            fin_d = 1'b0;
            chk_d = 1'b0;
            err_d = 1'b0;
        end else if (take) begin
            case (state_q)
                HDR_1: begin
                    src_d = in_data[31:16];
                    dst_d = in_data[15:0];
                    state_d = HDR_2;
                end
                HDR_2: begin
                    csum_d = in_data[15:0];
                    len_d = bad ? 16'd0 : l - UDP_HDR_BYTES;
                    left_d = l - UDP_HDR_BYTES;
                    err_d = bad;
                    state_d = bad ? ERR : l == UDP_HDR_BYTES ? DONE : DATA;
                end
                DATA: begin
                    out_wr_d = 1'b1;
                    out_data_d = masked;
                    out_keep_d = keep;
                    left_d = left_q - (left_q >= 16'd4 ? 16'd4 : left_q);
                    state_d = left_d == 16'd0 ? DONE : DATA;
                end
                default: ;
            endcase
        end else if (state_q == DONE) begin
            // Evaluated while sitting in DONE so the final payload word is already in the accumulator.
            fin_d = 1'b1;
            chk_d = !CHECK_EN || csum_q == CSUM_NONE || sum == CSUM_GOOD;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            left_q <= '0;
            csum_q <= '0;
            out_data_q <= '0;
            out_keep_q <= '0;
            out_wr_q <= 1'b0;
            fin_q <= 1'b0;
            chk_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q <= src_d;
            dst_q <= dst_d;
            len_q <= len_d;
            left_q <= left_d;
            csum_q <= csum_d;
            out_data_q <= out_data_d;
            out_keep_q <= out_keep_d;
            out_wr_q <= out_wr_d;
            fin_q <= fin_d;
            chk_q <= chk_d;
            err_q <= err_d;
        end
    end
    udp_csum_accum u_csum (
        .clk   (clk),
        .reset (reset),
        .clear (restart),
        .en    (take),
        .a     (masked[31:16]),
        .b     (masked[15:0]),
        .sum   (sum)
    );
    assign src_port = src_q;
    assign dest_port = dst_q;
    assign pay_len = len_q;
    assign out_data = out_data_q;
    assign out_keep = out_keep_q;
    assign out_wr = out_wr_q;
    assign fin = fin_q;
    assign chk_ok = chk_q;
    assign err = err_q;
endmodule

// File: tb/tb_udp_rx_decoder.sv
// tb_udp_rx_decoder: vector table, hand-written corner sequences and randomized datagrams against a byte-level model.
module tb_udp_rx_decoder;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, in_av = 1'b0;
    logic [31:0] in_data = '0;
    logic [15:0] src_port, dest_port, pay_len;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_wr, fin, chk_ok, err;
    int          checks = 0, errors = 0;
    logic [31:0] pw [0:7];
    logic [31:0] got_d [$];
    logic [3:0]  got_k [$];

    udp_rx_decoder dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_av(in_av),
        .src_port(src_port), .dest_port(dest_port), .pay_len(pay_len),
        .out_data(out_data), .out_keep(out_keep), .out_wr(out_wr),
        .fin(fin), .chk_ok(chk_ok), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (out_wr) begin
        got_d.push_back(out_data);
        got_k.push_back(out_keep);
    end

    typedef struct {
        logic [15:0] s, d, l, c;
        logic [31:0] w, xd;
        logic [3:0]  xk;
        logic        xbeat, xfin, xchk, xerr;
        logic [15:0] xlen;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] fold(input int t);
        while (t > 32'hFFFF) t = (t & 32'hFFFF) + (t >>> 16);
        return t[15:0];
    endfunction

    task automatic put_word(input logic [31:0] w, input int gap);
        in_data = w;
        in_av = 1'b1;
        @(posedge clk); #1;
        in_av = 1'b0;
        in_data = $urandom;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic run_dgram(input logic [15:0] s, d, l, c, input int gap);
        int n;
        got_d.delete();
        got_k.delete();
        start = 1'b1;
        in_data = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        put_word({s, d}, 0);
        put_word({l, c}, gap);
        if (l > 16'd8) for (int i = 0; i < (int'(l) - 8 + 3) / 4; i++) put_word(pw[i], gap);
        n = 0;
        while (!fin && !err && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        check("completion_seen", {31'd0, fin | err}, 32'd1);
    endtask

    initial begin
        tbl[0] = '{16'h1234, 16'h5678, 16'h000C, 16'hF9A9, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 1, 1, 1, 0, 16'd4};
        tbl[1] = '{16'h1234, 16'h5678, 16'h000C, 16'hF9A8, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 1, 1, 0, 0, 16'd4};
        tbl[2] = '{16'h0A0B, 16'h0C0D, 16'h000A, 16'h0000, 32'hABCD1122, 32'hABCD0000, 4'hC, 1, 1, 1, 0, 16'd2};
        tbl[3] = '{16'h0001, 16'h0002, 16'h0008, 16'hFFF4, 32'h0, 32'h0, 4'h0, 0, 1, 1, 0, 16'd0};
        tbl[4] = '{16'h0001, 16'h0002, 16'h0008, 16'h1234, 32'h0, 32'h0, 4'h0, 0, 1, 0, 0, 16'd0};
        tbl[5] = '{16'h0001, 16'h0002, 16'h0004, 16'h0000, 32'h0, 32'h0, 4'h0, 0, 0, 0, 1, 16'd0};
        tbl[6] = '{16'h4321, 16'h8765, 16'h0009, 16'h0000, 32'h11223344, 32'h11000000, 4'h8, 1, 1, 1, 0, 16'd1};
        tbl[7] = '{16'h4321, 16'h8765, 16'h000B, 16'h0000, 32'hA1B2C3D4, 32'hA1B2C300, 4'hE, 1, 1, 1, 0, 16'd3};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_outputs", {src_port, dest_port}, 32'd0);
        check("reset_flags", {pay_len, out_keep, out_wr, fin, chk_ok, err}, 24'd0);

        for (int i = 0; i < 8; i++) begin
            pw[0] = tbl[i].w;
            run_dgram(tbl[i].s, tbl[i].d, tbl[i].l, tbl[i].c, 0);
            check($sformatf("vec%0d_ports", i), {src_port, dest_port}, {tbl[i].s, tbl[i].d});
            check($sformatf("vec%0d_pay_len", i), pay_len, tbl[i].xlen);
            check($sformatf("vec%0d_fin_chk_err", i), {fin, chk_ok, err}, {tbl[i].xfin, tbl[i].xchk, tbl[i].xerr});
            check($sformatf("vec%0d_beats", i), got_d.size(), tbl[i].xbeat);
            if (tbl[i].xbeat && got_d.size() > 0) begin
                check($sformatf("vec%0d_data", i), got_d[0], tbl[i].xd);
                check($sformatf("vec%0d_keep", i), got_k[0], tbl[i].xk);
            end
        end

        pw[0] = 32'h01020304;
        pw[1] = 32'hA5A55A5A;
        run_dgram(16'h0101, 16'h0202, 16'h0010, 16'h0000, 3);
        check("stall_beats", got_d.size(), 2);
        if (got_d.size() == 2) begin
            check("stall_data0", got_d[0], 32'h01020304);
            check("stall_data1", got_d[1], 32'hA5A55A5A);
            check("stall_keep1", got_k[1], 4'hF);
        end
        check("stall_fin_chk", {fin, chk_ok}, 2'b11);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        put_word(32'h11112222, 0);
        put_word(32'h00100000, 0);
        put_word(32'hCAFEF00D, 0);
        reset = 1'b1;
        in_av = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        got_d.delete();
        check("abort_ports", {src_port, dest_port}, 32'd0);
        check("abort_data", out_data, 32'd0);
        check("abort_flags", {pay_len, out_keep, out_wr, fin, chk_ok, err}, 24'd0);
        repeat (4) begin in_data = $urandom; @(posedge clk); #1; end
        in_av = 1'b0;
        @(negedge clk);
        check("abort_no_beats", got_d.size(), 0);
        pw[0] = 32'hDEADBEEF;
        run_dgram(16'h1234, 16'h5678, 16'h000C, 16'hF9A9, 0);
        check("post_reset_ports", {src_port, dest_port, pay_len}, 48'h1234_5678_0004);
        check("post_reset_fin_chk", {fin, chk_ok, err}, 3'b110);
        check("post_reset_beat", got_d.size() == 1 ? got_d[0] : 32'hX, 32'hDEADBEEF);

        for (int it = 0; it < 40; it++) begin
            logic [15:0] s, d, l, c, xlen;
            logic [31:0] xw [0:7];
            logic [31:0] mask;
            logic [3:0]  xk [0:7];
            int n, nb, total;
            logic xchk;
            s = 16'($urandom);
            d = 16'($urandom);
            l = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 7)) : 16'(8 + $urandom_range(0, 24));
            for (int i = 0; i < 8; i++) pw[i] = $urandom;
            n = l > 16'd8 ? (int'(l) - 8 + 3) / 4 : 0;
            total = int'(s) + int'(d) + int'(l);
            for (int i = 0; i < n; i++) begin
                nb = int'(l) - 8 - 4 * i;
                if (nb > 4) nb = 4;
                mask = '0;
                for (int b = 0; b < 4; b++) if (b < nb) mask[31 - 8 * b -: 8] = 8'hFF;
                xw[i] = pw[i] & mask;
                xk[i] = 4'hF << (4 - nb);
                total += int'(xw[i][31:16]) + int'(xw[i][15:0]);
            end
            case ($urandom_range(0, 2))
                0: c = 16'h0000;
                1: c = ~fold(total);
                default: c = 16'($urandom);
            endcase
            xchk = l >= 16'd8 && (c == 16'h0000 || fold(total + int'(c)) == 16'hFFFF);
            xlen = l >= 16'd8 ? l - 16'd8 : 16'd0;
            run_dgram(s, d, l, c, $urandom_range(0, 2));
            check($sformatf("rnd%0d_ports", it), {src_port, dest_port}, {s, d});
            check($sformatf("rnd%0d_pay_len", it), pay_len, xlen);
            check($sformatf("rnd%0d_fin_chk_err", it), {fin, chk_ok, err}, {l >= 16'd8, xchk, l < 16'd8});
            check($sformatf("rnd%0d_beats", it), got_d.size(), n);
            if (got_d.size() == n)
                for (int i = 0; i < n; i++)
                    check($sformatf("rnd%0d_beat%0d", it, i), {got_k[i], got_d[i]}, {xk[i], xw[i]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
